// File: rtl/basic_sra_master.sv
// basic_sra_master: initiator end of the SRA request/response protocol.
// Issues one client read/write at a time, waits (bounded) for the reply.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_*               client command channel (valid/ready)
//   m_*                 SRA M->S request channel (user: 0 write, 1 read)
//   s_*                 SRA S->M response channel (user: 0 ok, 1 fail)
//   done_*              result back to client (valid/ready)
//   err_stray           sticky flag, response seen outside WAIT_RSP

module basic_sra_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_user,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_user,
  input  logic [DATA_W-1:0] s_data,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_fail,
  output logic              done_timeout,
  output logic [DATA_W-1:0] done_rdata,
  output logic              err_stray
);

  localparam int CW =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_user;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CW-1:0]     r_cnt;
  logic              r_fail;
  logic              r_tout;
  logic [DATA_W-1:0] r_rdata;
  logic              r_stray;

  state_t            w_state_nx;
  logic              w_user_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [DATA_W-1:0] w_data_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic              w_fail_nx;
  logic              w_tout_nx;
  logic [DATA_W-1:0] w_rdata_nx;
  logic              w_stray_nx;

  logic              w_s_ready;
  logic              w_cmd_ready;
  logic              w_rsp_fire;
  logic              w_cmd_fire;
  logic              w_expired;

  // Response channel is always open outside reset so the slave never
  // stalls; replies outside WAIT are dropped and flagged.
  assign w_s_ready   = !rst;
  assign w_cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_rsp_fire  = s_valid && w_s_ready;
  assign w_cmd_fire  = cmd_valid && w_cmd_ready;
  assign w_expired   = TO_EN && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_user_nx  = r_user;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_fail_nx  = r_fail;
    w_tout_nx  = r_tout;
    w_rdata_nx = r_rdata;
    w_stray_nx = r_stray;

    if (w_rsp_fire && (r_state != S_WAIT)) begin
      w_stray_nx = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_user_nx  = cmd_read;
          w_addr_nx  = cmd_addr;
          w_data_nx  = cmd_read ? '0 : cmd_wdata;
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (m_ready) begin
          w_cnt_nx   = '0;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
        // A response on the expiry cycle takes priority over timeout.
        if (w_rsp_fire) begin
          w_fail_nx  = s_user;
          w_tout_nx  = 1'b0;
          w_rdata_nx = (r_user && !s_user) ? s_data : '0;
          w_state_nx = S_DONE;
        end else if (w_expired) begin
          w_fail_nx  = 1'b1;
          w_tout_nx  = 1'b1;
          w_rdata_nx = '0;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_user  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_fail  <= 1'b0;
      r_tout  <= 1'b0;
      r_rdata <= '0;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_user  <= w_user_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_fail  <= w_fail_nx;
      r_tout  <= w_tout_nx;
      r_rdata <= w_rdata_nx;
      r_stray <= w_stray_nx;
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign s_ready      = w_s_ready;
  assign m_valid      = (r_state == S_REQ);
  assign m_user       = r_user;
  assign m_addr       = r_addr;
  assign m_data       = r_data;
  assign done_valid   = (r_state == S_DONE);
  assign done_fail    = r_fail;
  assign done_timeout = r_tout;
  assign done_rdata   = r_rdata;
  assign err_stray    = r_stray;

endmodule

// File: tb/tb_basic_sra_master.sv
// tb_basic_sra_master: directed bench for basic_sra_master.
// Expected results are queued at issue and popped at done handshake.

module tb_basic_sra_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        m_valid;
  logic        m_ready;
  logic        m_user;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_user;
  logic [31:0] s_data;
  logic        done_valid;
  logic        done_ready;
  logic        done_fail;
  logic        done_timeout;
  logic [31:0] done_rdata;
  logic        err_stray;

  typedef struct {
    logic        fail;
    logic        tout;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  basic_sra_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_read(cmd_read),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_user(m_user),
    .m_addr(m_addr),
    .m_data(m_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_user(s_user),
    .s_data(s_data),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_fail(done_fail),
    .done_timeout(done_timeout),
    .done_rdata(done_rdata),
    .err_stray(err_stray)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rd, input logic usr,
                      input logic [31:0] dat, input logic to);
    exp_t e;
    e.fail  = to ? 1'b1 : usr;
    e.tout  = to;
    e.rdata = (!to && rd && !usr) ? dat : 32'h0;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic rd, input logic [31:0] a,
                          input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits for done_valid, compares against scoreboard, handshakes.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!done_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_dv"}, 32'(done_valid), 32'h1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_fail"}, 32'(done_fail), 32'(e.fail));
      chk({tag, "_tout"}, 32'(done_timeout), 32'(e.tout));
      chk({tag, "_rdata"}, done_rdata, e.rdata);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk({tag, "_idle"}, 32'(done_valid), 32'h0);
  endtask

  // Issue with m_ready high and the response in the first WAIT cycle.
  task automatic run_txn(input string tag, input logic rd,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic usr, input logic [31:0] dat);
    push(rd, usr, dat, 1'b0);
    m_ready = 1'b1;
    send_cmd(rd, a, wd);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'h1);
    chk({tag, "_muser"}, 32'(m_user), 32'(rd));
    chk({tag, "_maddr"}, m_addr, a);
    chk({tag, "_mdata"}, m_data, rd ? 32'h0 : wd);
    tick();
    m_ready = 1'b0;
    chk({tag, "_mv_drop"}, 32'(m_valid), 32'h0);
    chk({tag, "_dv_early"}, 32'(done_valid), 32'h0);
    s_valid = 1'b1;
    s_user  = usr;
    s_data  = dat;
    tick();
    s_valid = 1'b0;
    chk({tag, "_lat"}, 32'(done_valid), 32'h1);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_read   = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    m_ready    = 1'b0;
    s_valid    = 1'b0;
    s_user     = 1'b0;
    s_data     = '0;
    done_ready = 1'b0;
    tick();
    tick();
    chk("rst_sready", 32'(s_ready), 32'h0);
    chk("rst_mvalid", 32'(m_valid), 32'h0);
    chk("rst_dvalid", 32'(done_valid), 32'h0);
    chk("rst_maddr", m_addr, 32'h0);
    chk("rst_drdata", done_rdata, 32'h0);
    chk("rst_stray", 32'(err_stray), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmdrdy", 32'(cmd_ready), 32'h1);
    chk("post_rst_sready", 32'(s_ready), 32'h1);

    // Plain write; write data must not leak into done_rdata.
    run_txn("wr", 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'hAAAA5555);
    wait_done("wr");
    chk("wr_stray", 32'(err_stray), 32'h0);

    // Read with request stalled for 5 cycles.
    push(1'b1, 1'b0, 32'h12345678, 1'b0);
    send_cmd(1'b1, 32'h20, 32'h99);
    for (int i = 0; i < 5; i++) begin
      chk("rd_stall_mv", 32'(m_valid), 32'h1);
      chk("rd_stall_addr", m_addr, 32'h20);
      chk("rd_stall_user", 32'(m_user), 32'h1);
      chk("rd_stall_data", m_data, 32'h0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_user  = 1'b0;
    s_data  = 32'h12345678;
    tick();
    s_valid = 1'b0;
    wait_done("rd");

    // Slave-reported failure on a read.
    run_txn("rdf", 1'b1, 32'h30, 32'h0, 1'b1, 32'h0000FFFF);
    wait_done("rdf");

    // Timeout: no response, done 4 cycles after request handshake.
    push(1'b1, 1'b0, 32'h0, 1'b1);
    m_ready = 1'b1;
    send_cmd(1'b1, 32'h40, 32'h0);
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait", 32'(done_valid), 32'h0);
    end
    tick();
    chk("to_fire", 32'(done_valid), 32'h1);
    wait_done("to");
    chk("to_stray_pre", 32'(err_stray), 32'h0);
    s_valid = 1'b1;
    s_data  = 32'h0BAD0BAD;
    tick();
    s_valid = 1'b0;
    chk("late_stray", 32'(err_stray), 32'h1);
    chk("late_dv", 32'(done_valid), 32'h0);

    // Response on the exact expiry cycle wins over timeout.
    push(1'b1, 1'b0, 32'hCAFE0001, 1'b0);
    m_ready = 1'b1;
    send_cmd(1'b1, 32'h50, 32'h0);
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("race_dv", 32'(done_valid), 32'h0);
    s_valid = 1'b1;
    s_user  = 1'b0;
    s_data  = 32'hCAFE0001;
    tick();
    s_valid = 1'b0;
    wait_done("race");

    // Reset mid-WAIT abandons the transaction.
    m_ready = 1'b1;
    send_cmd(1'b0, 32'h60, 32'h1111);
    tick();
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_sready", 32'(s_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmdrdy", 32'(cmd_ready), 32'h1);
    chk("mid_rst_stray", 32'(err_stray), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_nodone", 32'(done_valid), 32'h0);
    end

    // done_ready held off while the client already offers a command.
    run_txn("hold", 1'b1, 32'h70, 32'h0, 1'b0, 32'h76543210);
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = 32'h80;
    cmd_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_dv", 32'(done_valid), 32'h1);
      chk("hold_rdata", done_rdata, 32'h76543210);
      chk("hold_cmdrdy", 32'(cmd_ready), 32'h0);
      chk("hold_mv", 32'(m_valid), 32'h0);
    end
    wait_done("hold");
    chk("reacc_rdy", 32'(cmd_ready), 32'h1);
    chk("reacc_mv0", 32'(m_valid), 32'h0);
    push(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("reacc_mv1", 32'(m_valid), 32'h1);
    chk("reacc_addr", m_addr, 32'h80);
    chk("reacc_data", m_data, 32'h55);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_user  = 1'b0;
    s_data  = 32'h3333;
    tick();
    s_valid = 1'b0;
    wait_done("reacc");

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("stray_sticky", 32'(err_stray), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_sra_master.md
Name: basic_sra_master

Overview:
- Initiator end of the SRA protocol; counterpart of the basic SRA slave.
- Takes single read/write commands from a local client and issues them on the SRA M->S request channel.
  - Request user bit: 1'h0 = write, 1'h1 = read.
- Waits for the S->M response, then returns status and read data to the client.
  - Response user bit: 1'h0 = success, 1'h1 = fail.
- One transaction outstanding at a time; response wait is bounded by a timeout.

Parameters:
ADDR_W, 32, width of request address
DATA_W, 32, width of request/response data
TIMEOUT_CYCLES, 256, max cycles in WAIT_RSP before abort; 0 disables timeout

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  client command valid
cmd_ready  out  1  client command ready
cmd_read  in  1  1 = read, 0 = write
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data (ignored for reads)
m_valid  out  1  SRA request valid
m_ready  in  1  SRA request ready (from slave)
m_user  out  1  SRA request user bit (0 write, 1 read)
m_addr  out  ADDR_W  SRA request address
m_data  out  DATA_W  SRA request data (0 for reads)
s_valid  in  1  SRA response valid (from slave)
s_ready  out  1  SRA response ready
s_user  in  1  SRA response user bit (0 success, 1 fail)
s_data  in  DATA_W  SRA response data
done_valid  out  1  result valid to client
done_ready  in  1  client accepts result
done_fail  out  1  slave reported fail, or timeout
done_timeout  out  1  result caused by timeout
done_rdata  out  DATA_W  read data (0 for writes and failures)
err_stray  out  1  sticky: a response arrived outside WAIT_RSP

Behaviour:
- Reset (rst high at a rising edge):
  - Next state IDLE; timeout counter and err_stray cleared.
  - m_valid=0, done_valid=0, all payload outputs 0.
  - s_ready=0 during the reset cycle; cmd_ready=1 the cycle after.
  - Reset mid-transaction abandons it with no done_valid.
- States: IDLE, REQ, WAIT_RSP, DONE. Outputs are decoded from registered state and regs.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register m_user=cmd_read, m_addr, m_data (cmd_wdata, or 0 if read); go to REQ.
- REQ:
  - m_valid=1; m_user/m_addr/m_data held stable until m_valid&&m_ready.
  - On handshake: clear counter; go to WAIT_RSP.
  - No timeout in REQ; m_valid never drops without a handshake.
- WAIT_RSP:
  - Counter increments each cycle.
  - On s_valid (s_ready=1): register done_fail=s_user, done_timeout=0, done_rdata=(read && !s_user) ? s_data : 0; go to DONE.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: done_fail=1, done_timeout=1, done_rdata=0; go to DONE.
  - If s_valid and timeout coincide, the response wins.
- DONE:
  - done_valid=1, result held until done_ready; then go to IDLE.
  - cmd_ready=0 in DONE, so the next command is accepted no earlier than the cycle after IDLE is re-entered.
- s_ready is 1 in every state after reset, so the slave is never stalled.
  - A response accepted in IDLE, REQ or DONE (including the same cycle as the request handshake) is discarded and sets err_stray.
  - err_stray clears only on rst.
- Minimum latency with m_ready and s_valid immediately high:
  - command accepted at cycle N; m_valid at N+1; response accepted at N+2; done_valid at N+3.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.

Test Plan:
- Write, addr 0x10, data 0xDEADBEEF; m_ready and s_valid tied 1; s_user=0 -> m_user=0, m_data=0xDEADBEEF at N+1; done_valid at N+3, done_fail=0, done_rdata=0.
- Read, addr 0x20; m_ready held low 5 cycles; s_data=0x12345678, s_user=0 -> m_valid and payload stable for 5 cycles; done_rdata=0x12345678, done_fail=0.
- Read with s_user=1, s_data=0xFFFF -> done_fail=1, done_timeout=0, done_rdata=0.
- TIMEOUT_CYCLES=4; no response -> done_valid 4 cycles after request handshake, done_fail=1, done_timeout=1. A late s_valid in IDLE is absorbed and err_stray=1.
- s_valid arrives on the exact timeout cycle -> response result reported, done_timeout=0. Separately, rst pulsed in WAIT_RSP -> next cycle IDLE, cmd_ready=1, no done_valid, err_stray=0.
- done_ready held low 3 cycles while cmd_valid=1 -> result stable; cmd_ready=0 throughout DONE; new command accepted one cycle after done handshake.
